branch_resolve: RTL

//  ID-stage branch resolver of the 16-bit WISC pipeline; the reader/consumer end of the ALU {Z,V,N} flag interface.

---
 rtl/wisc_pkg.sv | 33 +++
 rtl/branch_resolve_cond_eval.sv | 40 ++++
 rtl/branch_resolve.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wisc_pkg
//  Description : Shared definitions for the WISC ID-stage branch resolver:
//                condition codes, flag bit indices and the resolver state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package wisc_pkg;

  // Condition codes carried in instr[11:9]
  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_AL = 3'b111;

  // Bit positions inside the {Z,V,N} flag vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } br_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Combinational branch-condition evaluator.
//  Ports       : cond  (in, 3)  condition code
//                flags (in, 3)  {Z,V,N}
//                take  (out, 1) condition satisfied
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       take
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_NE: take = ~z;
      COND_EQ: take = z;
      COND_GT: take = ~z & ~n;
      COND_LT: take = n;
      COND_GE: take = z | ~n;   // Z=1 or (Z=0 and N=0) reduces to Z | ~N
      COND_LE: take = n | z;
      COND_OV: take = v;
      COND_AL: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : ID-stage branch resolver. Shadows the ALU {Z,V,N} flags,
//                evaluates B/BR conditions, computes the target, waits one
//                cycle on a same-cycle flag update, and drives redirect/flush
//                towards IF/ID. Keeps saturating resolved/taken counters.
//  Ports       : clk, rst (async, active-low)
//                flags_wr/flags_in    ALU flag update
//                valid_in, is_br, cond, imm9, pc_plus2, rs_data  branch request
//                stall_ext            freeze everything
//                stall, redirect, target, flush          pipeline control
//                taken_cnt, branch_cnt                   perf counters
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
  import wisc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flags_wr,
  input  logic [2:0]       flags_in,
  input  logic             valid_in,
  input  logic             is_br,
  input  logic [2:0]       cond,
  input  logic [8:0]       imm9,
  input  logic [15:0]      pc_plus2,
  input  logic [15:0]      rs_data,
  input  logic             stall_ext,
  output logic             stall,
  output logic             redirect,
  output logic [15:0]      target,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  localparam logic [1:0] C_FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  br_state_e        state_q, state_d;
  logic [2:0]       flag_q, flag_d;
  logic [2:0]       cond_q, cond_d;
  logic [15:0]      target_q, target_d;
  logic             redirect_q, redirect_d;
  logic             flush_q, flush_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

  logic [15:0] w_req_target;
  logic [2:0]  w_eval_cond;
  logic        w_take;
  logic        w_resolve;

  // imm9 is a word offset: sign-extend and shift left by one.
  assign w_req_target = is_br ? rs_data
                              : pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};

  // In WAIT the latched condition is evaluated against the freshly written flags.
  assign w_eval_cond = (state_q == WAIT) ? cond_q : cond;

  cond_eval u_cond_eval (
    .cond  (w_eval_cond),
    .flags (flag_q),
    .take  (w_take)
  );

  always_comb begin
    state_d      = state_q;
    flag_d       = flags_wr ? flags_in : flag_q;
    cond_d       = cond_q;
    target_d     = target_q;
    redirect_d   = redirect_q;
    flush_d      = flush_q;
    fcnt_d       = fcnt_q;
    taken_cnt_d  = taken_cnt_q;
    branch_cnt_d = branch_cnt_q;
    w_resolve    = 1'b0;

    if (!stall_ext) begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            target_d = w_req_target;
            cond_d   = cond;
            if (flags_wr) state_d = WAIT;
            else          w_resolve = 1'b1;
          end
        end
        WAIT: w_resolve = 1'b1;
        FLUSH: begin
          redirect_d = 1'b0;
          if (fcnt_q == 2'd0) begin
            flush_d = 1'b0;
            state_d = IDLE;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (w_resolve) begin
        if (~&branch_cnt_q) branch_cnt_d = branch_cnt_q + 1'b1;
        if (w_take) begin
          if (~&taken_cnt_q) taken_cnt_d = taken_cnt_q + 1'b1;
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          fcnt_d     = C_FCNT_INIT;
          state_d    = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      flag_q       <= 3'b000;
      cond_q       <= 3'b000;
      target_q     <= 16'h0000;
      redirect_q   <= 1'b0;
      flush_q      <= 1'b0;
      fcnt_q       <= 2'd0;
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      flag_q       <= flag_d;
      cond_q       <= cond_d;
      target_q     <= target_d;
      redirect_q   <= redirect_d;
      flush_q      <= flush_d;
      fcnt_q       <= fcnt_d;
      taken_cnt_q  <= taken_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  // Hazard stall is raised in the request cycle itself so IF/ID hold at once;
  // gated by rst so it reads 0 while reset is held.
  assign stall = rst & ((state_q == WAIT) |
                        ((state_q == IDLE) & valid_in & flags_wr & ~stall_ext));

  assign redirect   = redirect_q;
  assign target     = target_q;
  assign flush      = flush_q;
  assign taken_cnt  = taken_cnt_q;
  assign branch_cnt = branch_cnt_q;

endmodule
`default_nettype wire
